// File: rtl/ch0re_hazard_unit.sv
// ch0re hazard/forwarding unit: DEPTH-entry in-flight history, operand bypass, load-use stall.
// Define CH0RE_HZ_PERF_EN to add the o_perf_stalls stall-cycle counter.
module ch0re_hazard_unit #(
  parameter int XLEN       = 64,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int RADDR_W    = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_id_valid,
  input  logic [RADDR_W-1:0]           i_id_rs1,
  input  logic [RADDR_W-1:0]           i_id_rs2,
  input  logic                         i_id_rs1_used,
  input  logic                         i_id_rs2_used,
  input  logic [RADDR_W-1:0]           i_id_rd,
  input  logic                         i_id_wen,
  input  logic                         i_id_is_load,
  input  logic                         i_flush,
  input  logic [XLEN-1:0]              i_rf_rdata1,
  input  logic [XLEN-1:0]              i_rf_rdata2,
  input  logic [DEPTH*XLEN-1:0]        i_stage_data,
  output logic [XLEN-1:0]              o_rs1_val,
  output logic [XLEN-1:0]              o_rs2_val,
  output logic [$clog2(DEPTH+1)-1:0]   o_fwd1_sel,
  output logic [$clog2(DEPTH+1)-1:0]   o_fwd2_sel,
`ifdef CH0RE_HZ_PERF_EN
  output logic [31:0]                  o_perf_stalls,
`endif
  output logic                         o_stall
);

  localparam int SEL_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]   histValid_q, histValid_d;
  logic [DEPTH-1:0]   histWen_q,   histWen_d;
  logic [DEPTH-1:0]   histLoad_q,  histLoad_d;
  logic [RADDR_W-1:0] histRd_q [DEPTH];
  logic [RADDR_W-1:0] histRd_d [DEPTH];
  logic               hazard1, hazard2;

  // Walk oldest to youngest so the youngest matching stage overrides the rest.
  function automatic logic [XLEN+SEL_W:0] resolve(input logic [RADDR_W-1:0] rs,
                                                   input logic               used,
                                                   input logic [XLEN-1:0]    rfData);
    logic [XLEN-1:0]  val;
    logic [SEL_W-1:0] sel;
    logic             haz;
    val = (rs == '0) ? '0 : rfData;
    sel = '0;
    haz = 1'b0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (used && (rs != '0) && histValid_q[k] && histWen_q[k] && (histRd_q[k] == rs)) begin
        val = i_stage_data[k*XLEN +: XLEN];
        sel = SEL_W'(k+1);
        haz = histLoad_q[k] && (k < LOAD_STAGE);
      end
    end
    return {haz, sel, val};
  endfunction

  always_comb begin
    {hazard1, o_fwd1_sel, o_rs1_val} = resolve(i_id_rs1, i_id_rs1_used, i_rf_rdata1);
    {hazard2, o_fwd2_sel, o_rs2_val} = resolve(i_id_rs2, i_id_rs2_used, i_rf_rdata2);
  end

  assign o_stall = i_id_valid & ~i_flush & (hazard1 | hazard2);

  // A stalled or flushed ID slot enters the history as a bubble.
  always_comb begin
    histValid_d[0] = i_id_valid & ~i_flush & ~o_stall;
    histWen_d[0]   = i_id_wen;
    histLoad_d[0]  = i_id_is_load;
    histRd_d[0]    = i_id_rd;
    for (int k = 1; k < DEPTH; k++) begin
      histValid_d[k] = histValid_q[k-1];
      histWen_d[k]   = histWen_q[k-1];
      histLoad_d[k]  = histLoad_q[k-1];
      histRd_d[k]    = histRd_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      histValid_q <= '0;
      histWen_q   <= '0;
      histLoad_q  <= '0;
      for (int k = 0; k < DEPTH; k++) histRd_q[k] <= '0;
    end else begin
      histValid_q <= histValid_d;
      histWen_q   <= histWen_d;
      histLoad_q  <= histLoad_d;
      for (int k = 0; k < DEPTH; k++) histRd_q[k] <= histRd_d[k];
    end
  end

`ifdef CH0RE_HZ_PERF_EN
  logic [31:0] perfStalls_q, perfStalls_d;

  assign perfStalls_d  = o_stall ? perfStalls_q + 32'd1 : perfStalls_q;
  assign o_perf_stalls = perfStalls_q;

  always_ff @(posedge clk) begin
    if (!rst_n) perfStalls_q <= '0;
    else        perfStalls_q <= perfStalls_d;
  end
`endif

endmodule

// File: tb/tb_ch0re_hazard_unit.sv
// Self-checking bench for ch0re_hazard_unit: queue-based history model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ch0re_hazard_unit;
  localparam int XLEN       = 64;
  localparam int DEPTH      = 3;
  localparam int LOAD_STAGE = 2;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       load;
  } ent_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  idValid = 1'b0;
  logic [4:0]            rs1 = '0, rs2 = '0, rd = '0;
  logic                  rs1Used = 1'b0, rs2Used = 1'b0, wen = 1'b0, isLoad = 1'b0, flush = 1'b0;
  logic [XLEN-1:0]       rf1 = 64'hF1F1_0000_0000_0001, rf2 = 64'hF2F2_0000_0000_0002;
  logic [DEPTH*XLEN-1:0] stageData = '0;
  logic [XLEN-1:0]       rs1Val, rs2Val;
  logic [1:0]            fwd1Sel, fwd2Sel;
  logic                  stall;
`ifdef CH0RE_HZ_PERF_EN
  logic [31:0]           perfStalls;
  logic [31:0]           expPerf = '0;
`endif

  int   checks = 0;
  int   errors = 0;
  bit   checking = 1'b0;
  ent_t hq[$];

  ch0re_hazard_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .RADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .i_id_valid(idValid), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_rs1_used(rs1Used), .i_id_rs2_used(rs2Used), .i_id_rd(rd), .i_id_wen(wen),
    .i_id_is_load(isLoad), .i_flush(flush), .i_rf_rdata1(rf1), .i_rf_rdata2(rf2),
    .i_stage_data(stageData), .o_rs1_val(rs1Val), .o_rs2_val(rs2Val),
    .o_fwd1_sel(fwd1Sel), .o_fwd2_sel(fwd2Sel),
`ifdef CH0RE_HZ_PERF_EN
    .o_perf_stalls(perfStalls),
`endif
    .o_stall(stall));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Youngest in-flight writer of rs supplies the operand; a load too young to have data stalls.
  function automatic void lookup(input logic [4:0] rs, input logic used, input logic [63:0] rf,
                                 output logic [63:0] val, output logic [1:0] sel, output logic haz);
    val = (rs == 0) ? 64'd0 : rf;
    sel = 0;
    haz = 0;
    if (used && rs != 0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (hq[k].valid && hq[k].wen && hq[k].rd == rs) begin
          val = stageData[k*XLEN +: XLEN];
          sel = 2'(k + 1);
          haz = hq[k].load && (k < LOAD_STAGE);
          break;
        end
      end
    end
  endfunction

  function automatic logic modelStall();
    logic [63:0] v;
    logic [1:0]  s;
    logic        h1, h2;
    lookup(rs1, rs1Used, rf1, v, s, h1);
    lookup(rs2, rs2Used, rf2, v, s, h2);
    return idValid && !flush && (h1 || h2);
  endfunction

  initial for (int k = 0; k < DEPTH; k++) hq.push_back('0);

  always @(posedge clk) begin
    ent_t e;
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) hq[k] = '0;
`ifdef CH0RE_HZ_PERF_EN
      expPerf = '0;
`endif
    end else begin
      logic st;
      st = modelStall();
`ifdef CH0RE_HZ_PERF_EN
      if (st) expPerf = expPerf + 32'd1;
`endif
      e.valid = idValid && !flush && !st;
      e.rd    = rd;
      e.wen   = wen;
      e.load  = isLoad;
      hq.push_front(e);
      void'(hq.pop_back());
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      logic [63:0] v1, v2;
      logic [1:0]  s1, s2;
      logic        h1, h2;
      lookup(rs1, rs1Used, rf1, v1, s1, h1);
      lookup(rs2, rs2Used, rf2, v2, s2, h2);
      checkOutput("model_stall", 64'(stall), 64'(modelStall()));
      if (idValid) begin
        checkOutput("model_sel1", 64'(fwd1Sel), 64'(s1));
        checkOutput("model_val1", rs1Val, v1);
        checkOutput("model_sel2", 64'(fwd2Sel), 64'(s2));
        checkOutput("model_val2", rs2Val, v2);
      end
`ifdef CH0RE_HZ_PERF_EN
      checkOutput("model_perf", 64'(perfStalls), 64'(expPerf));
`endif
    end
  end

  task automatic applyStimulus(input logic v, input logic [4:0] a1, input logic u1,
                               input logic [4:0] a2, input logic u2, input logic [4:0] d,
                               input logic w, input logic ld, input logic fl);
    @(posedge clk);
    #1;
    idValid = v; rs1 = a1; rs1Used = u1; rs2 = a2; rs2Used = u2;
    rd = d; wen = w; isLoad = ld; flush = fl;
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++)
      stageData[k*XLEN +: XLEN] = 64'hA000_0000_0000_0000 | 64'(k + 1);

    repeat (2) @(posedge clk);
    applyStimulus(1, 5'd5, 1, 5'd6, 1, 5'd0, 0, 0, 0);
    checking = 1'b1;
    checkOutput("reset_stall", 64'(stall), 64'd0);
    checkOutput("reset_sel1", 64'(fwd1Sel), 64'd0);
    checkOutput("reset_val1", rs1Val, rf1);
    checkOutput("reset_val2", rs2Val, rf2);
    rst_n = 1'b1;

    // forward from EX
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);
    applyStimulus(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("ex_fwd_sel1", 64'(fwd1Sel), 64'd1);
    checkOutput("ex_fwd_val1", rs1Val, 64'hA000_0000_0000_0001);
    checkOutput("ex_fwd_stall", 64'(stall), 64'd0);

    // youngest wins: x7 written at k=2 and k=0
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0);
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0);
    applyStimulus(1, 5'd7, 1, 5'd7, 1, 5'd0, 0, 0, 0);
    checkOutput("young_sel1", 64'(fwd1Sel), 64'd1);
    checkOutput("young_sel2", 64'(fwd2Sel), 64'd1);
    checkOutput("young_val1", rs1Val, 64'hA000_0000_0000_0001);
    applyStimulus(1, 5'd0, 1, 5'd7, 1, 5'd0, 0, 0, 0);
    checkOutput("x0_sel1", 64'(fwd1Sel), 64'd0);
    checkOutput("x0_val1", rs1Val, 64'd0);
    checkOutput("x0_sel2", 64'(fwd2Sel), 64'd2);

    // load-use: two stall cycles, then forward from WB
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1, 0);
    applyStimulus(1, 5'd0, 0, 5'd3, 1, 5'd9, 1, 0, 0);
    checkOutput("lu_stall_c1", 64'(stall), 64'd1);
    applyStimulus(1, 5'd0, 0, 5'd3, 1, 5'd9, 1, 0, 0);
    checkOutput("lu_stall_c2", 64'(stall), 64'd1);
    applyStimulus(1, 5'd0, 0, 5'd3, 1, 5'd9, 1, 0, 0);
    checkOutput("lu_stall_c3", 64'(stall), 64'd0);
    checkOutput("lu_sel2", 64'(fwd2Sel), 64'd3);
    checkOutput("lu_val2", rs2Val, 64'hA000_0000_0000_0003);
    applyStimulus(1, 5'd9, 1, 5'd3, 1, 5'd0, 0, 0, 0);
    checkOutput("lu_bubble_sel1", 64'(fwd1Sel), 64'd1);
    checkOutput("lu_gone_sel2", 64'(fwd2Sel), 64'd0);

    // flush beats load-use hazard and leaves a bubble
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 1, 0);
    applyStimulus(1, 5'd4, 1, 5'd0, 0, 5'd10, 1, 0, 1);
    checkOutput("flush_stall", 64'(stall), 64'd0);
    applyStimulus(1, 5'd10, 1, 5'd4, 1, 5'd0, 0, 0, 0);
    checkOutput("flush_bubble_sel1", 64'(fwd1Sel), 64'd0);
    checkOutput("flush_then_stall", 64'(stall), 64'd1);
    applyStimulus(1, 5'd10, 1, 5'd4, 1, 5'd0, 0, 0, 0);
    checkOutput("flush_release", 64'(stall), 64'd0);

    // rd=x0 load never matches
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0);
    applyStimulus(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0);
    checkOutput("rd0_stall", 64'(stall), 64'd0);

    // invalid ID never stalls
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd20, 1, 1, 0);
    applyStimulus(0, 5'd20, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("invalid_stall", 64'(stall), 64'd0);
    applyStimulus(1, 5'd20, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("after_invalid_stall", 64'(stall), 64'd1);
    applyStimulus(1, 5'd20, 1, 5'd0, 0, 5'd0, 0, 0, 0);

    // reset mid-stall clears history
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd11, 1, 0, 0);
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd12, 1, 0, 0);
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd13, 1, 1, 0);
    applyStimulus(1, 5'd13, 1, 5'd12, 1, 5'd0, 0, 0, 0);
    checkOutput("mid_rst_pre_stall", 64'(stall), 64'd1);
    rst_n = 1'b0;
    applyStimulus(1, 5'd13, 1, 5'd12, 1, 5'd0, 0, 0, 0);
    checkOutput("mid_rst_stall", 64'(stall), 64'd0);
    checkOutput("mid_rst_sel1", 64'(fwd1Sel), 64'd0);
    checkOutput("mid_rst_sel2", 64'(fwd2Sel), 64'd0);
    checkOutput("mid_rst_val2", rs2Val, rf2);
    rst_n = 1'b1;

    // mixed traffic on a small register set, checked by the model
    for (int i = 0; i < 60; i++) begin
      rf1 = {$urandom, $urandom};
      rf2 = {$urandom, $urandom};
      for (int k = 0; k < DEPTH; k++) stageData[k*XLEN +: XLEN] = {$urandom, $urandom};
      applyStimulus($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 1'($urandom),
                    5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                    1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
    end

    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
